// File: rtl/proc_bus_responder.sv
// Memory-bus responder: decodes addr[8:7] into RAM / LEDR / HEX / SW and serves reads and writes.
// Latency: writes take effect at the end of the write cycle; read data and rd_valid appear READ_LAT cycles after accept.
// Backpressure: busy=1 while a read is in flight; rd_req is dropped (not queued) while busy or when wr is also high.
// Optional: define PROC_BUS_RESP_SW_SYNC_EN to pass sw through a 2-flop synchronizer before it is readable.
module proc_bus_responder #(
    parameter int DW       = 9,
    parameter int AW       = 7,
    parameter int READ_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [8:0]    addr,
    input  logic [DW-1:0] wdata,
    input  logic          wr,
    input  logic          rd_req,
    input  logic [DW-1:0] sw,
    output logic [DW-1:0] rdata,
    output logic          rd_valid,
    output logic          busy,
    output logic [DW-1:0] ledr,
    output logic [DW-1:0] hex,
    output logic          wr_err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} state_t;

    localparam logic [1:0] REG_RAM = 2'b00;
    localparam logic [1:0] REG_LED = 2'b01;
    localparam logic [1:0] REG_HEX = 2'b10;
    localparam logic [1:0] REG_SW  = 2'b11;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] samp_q, samp_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rd_valid_q, rd_valid_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] ledr_q, ledr_d;
    logic [DW-1:0] hex_q, hex_d;
    logic          wr_err_q, wr_err_d;

    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] sw_rd;
    logic [DW-1:0] tgt_dat;
    logic [1:0]    region;
    logic [AW-1:0] idx;
    logic          accept;

    assign region = addr[8:7];
    assign idx    = addr[AW-1:0];

`ifdef PROC_BUS_RESP_SW_SYNC_EN
    logic [DW-1:0] sw_s1_q, sw_s2_q;

    // Two-stage synchronizer for the asynchronous board switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
        end
    end

    assign sw_rd = sw_s2_q;
`else
    assign sw_rd = sw;
`endif

    // Read mux over the four targets; RAM index wraps because upper bits are dropped.
    always_comb begin
        tgt_dat = '0;
        case (region)
            REG_RAM: tgt_dat = ram[idx];
            REG_LED: tgt_dat = ledr_q;
            REG_HEX: tgt_dat = hex_q;
            REG_SW:  tgt_dat = sw_rd;
            default: tgt_dat = '0;
        endcase
    end

    // A read is only taken when idle and not colliding with a write.
    assign accept = (state_q == IDLE) && rd_req && !wr;

    // Next-state logic: register writes, read FSM and the registered read outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        samp_d   = samp_q;
        ledr_d   = ledr_q;
        hex_d    = hex_q;
        wr_err_d = wr_err_q;

        if (wr) begin
            case (region)
                REG_LED: ledr_d   = wdata;
                REG_HEX: hex_d    = wdata;
                REG_SW:  wr_err_d = 1'b1;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    samp_d  = tgt_dat;
                    cnt_d   = 3'(READ_LAT - 1);
                    state_d = (READ_LAT == 1) ? RD_RESP : RD_WAIT;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // rd_valid/rdata are registered so they line up with the RD_RESP cycle.
        rd_valid_d = (state_d == RD_RESP);
        busy_d     = (state_d != IDLE);
        rdata_d    = rdata_q;
        if (state_d == RD_RESP) begin
            // With a one-cycle latency the snapshot register is not loaded yet.
            rdata_d = (state_q == IDLE) ? tgt_dat : samp_q;
        end
    end

    // FSM and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            samp_q     <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ledr_q     <= '0;
            hex_q      <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            samp_q     <= samp_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            ledr_q     <= ledr_d;
            hex_q      <= hex_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr && (region == REG_RAM)) begin
            ram[idx] <= wdata;
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign ledr     = ledr_q;
    assign hex      = hex_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_proc_bus_responder.sv
// Bench for proc_bus_responder: three instances (READ_LAT 1, 2, 4) share one stimulus stream.
// Expected read words and their due cycles are queued per instance at request time and popped on rd_valid.
// Register outputs are compared against a small bench-side model of RAM, LEDR, HEX and wr_err.
module tb_proc_bus_responder;

    localparam int DW = 9;
    localparam int AW = 7;
    localparam int LAT [3] = '{1, 2, 4};

    typedef struct {
        logic [DW-1:0] dat;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [8:0]    addr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic          rd_req;
    logic [DW-1:0] sw;

    logic [DW-1:0] rdata_w  [3];
    logic          rvld_w   [3];
    logic          busy_w   [3];
    logic [DW-1:0] ledr_w   [3];
    logic [DW-1:0] hex_w    [3];
    logic          wr_err_w [3];

    exp_t sbq [3][$];

    logic [DW-1:0] ram_m [2**AW];
    logic [DW-1:0] ledr_m, hex_m;
    logic          err_m;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    proc_bus_responder #(.DW(DW), .AW(AW), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr(wr), .rd_req(rd_req), .sw(sw),
        .rdata(rdata_w[0]), .rd_valid(rvld_w[0]), .busy(busy_w[0]),
        .ledr(ledr_w[0]), .hex(hex_w[0]), .wr_err(wr_err_w[0]));

    proc_bus_responder #(.DW(DW), .AW(AW), .READ_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr(wr), .rd_req(rd_req), .sw(sw),
        .rdata(rdata_w[1]), .rd_valid(rvld_w[1]), .busy(busy_w[1]),
        .ledr(ledr_w[1]), .hex(hex_w[1]), .wr_err(wr_err_w[1]));

    proc_bus_responder #(.DW(DW), .AW(AW), .READ_LAT(4)) u_lat4 (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr(wr), .rd_req(rd_req), .sw(sw),
        .rdata(rdata_w[2]), .rd_valid(rvld_w[2]), .busy(busy_w[2]),
        .ledr(ledr_w[2]), .hex(hex_w[2]), .wr_err(wr_err_w[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [8:0] a);
        case (a[8:7])
            2'b00:   return ram_m[a[AW-1:0]];
            2'b01:   return ledr_m;
            2'b10:   return hex_m;
            default: return sw;
        endcase
    endfunction

    task automatic model_wr(input logic [8:0] a, input logic [DW-1:0] d);
        case (a[8:7])
            2'b00:   ram_m[a[AW-1:0]] = d;
            2'b01:   ledr_m = d;
            2'b10:   hex_m = d;
            default: err_m = 1'b1;
        endcase
    endtask

    task automatic push_all(input logic [DW-1:0] d, input int n);
        for (int i = 0; i < 3; i++) sbq[i].push_back('{dat: d, cyc: n + LAT[i]});
    endtask

    task automatic wr_op(input logic [8:0] a, input logic [DW-1:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        model_wr(a, d);
        step();
        wr = 1'b0;
    endtask

    // One isolated read; also checks the LAT=2 busy window and rdata hold afterwards.
    task automatic rd_op(input logic [8:0] a);
        logic [DW-1:0] e;
        e      = model_rd(a);
        addr   = a;
        rd_req = 1'b1;
        push_all(e, cyc);
        step();
        rd_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("busy_lat2_k%0d", k), 32'(busy_w[1]), 32'(k <= 2));
            step();
        end
        idle(3);
        check("rdata_hold_lat2", 32'(rdata_w[1]), 32'(e));
        check("rdata_hold_lat4", 32'(rdata_w[2]), 32'(e));
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_ledr%0d", tag, i), 32'(ledr_w[i]), 32'(ledr_m));
            check($sformatf("%s_hex%0d", tag, i), 32'(hex_w[i]), 32'(hex_m));
            check($sformatf("%s_err%0d", tag, i), 32'(wr_err_w[i]), 32'(err_m));
        end
    endtask

    // Scoreboard: every rd_valid pulse must match the oldest queued word and its due cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rvld_w[i] === 1'b1) begin
                if (sbq[i].size() == 0) begin
                    check($sformatf("spurious_rd_valid_lat%0d", LAT[i]), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq[i].pop_front();
                    check($sformatf("rdata_lat%0d", LAT[i]), 32'(rdata_w[i]), 32'(e.dat));
                    check($sformatf("rd_cycle_lat%0d", LAT[i]), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; wr = 1'b0; rd_req = 1'b0; sw = '0;
        ledr_m = '0; hex_m = '0; err_m = 1'b0;
        for (int k = 0; k < 2**AW; k++) ram_m[k] = 'x;
        idle(2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_rdata%0d", i), 32'(rdata_w[i]), 32'd0);
            check($sformatf("rst_rvld%0d", i), 32'(rvld_w[i]), 32'd0);
            check($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
        end
        chk_regs("rst");
        rst = 1'b0;
        step();

        // RAM write then read.
        wr_op(9'h005, 9'h1A3);
        rd_op(9'h005);

        // LED and HEX registers.
        wr_op(9'h080, 9'h055);
        check("ledr_next", 32'(ledr_w[0]), 32'h055);
        check("hex_untouched", 32'(hex_w[0]), 32'h000);
        rd_op(9'h080);
        wr_op(9'h100, 9'h13C);
        chk_regs("hexwr");
        rd_op(9'h100);

        // Read-only region: write is refused and flagged.
        wr_op(9'h000, 9'h0AA);
        wr_op(9'h180, 9'h1EE);
        chk_regs("rowr");
        rd_op(9'h000);
        sw = 9'h12C;
        idle(3);
        rd_op(9'h180);

        // Collision: write wins, read dropped.
        addr = 9'h010; wdata = 9'h0F0; wr = 1'b1; rd_req = 1'b1;
        model_wr(9'h010, 9'h0F0);
        step();
        wr = 1'b0; rd_req = 1'b0;
        idle(6);
        rd_op(9'h010);

        // Second request while busy is dropped: exactly one response.
        addr = 9'h005; rd_req = 1'b1;
        push_all(model_rd(9'h005), cyc);
        step();
        check("busy_on_2nd_req", 32'(busy_w[0]), 32'd1);
        step();
        rd_req = 1'b0;
        idle(6);

        // Write to the in-flight address does not alter the snapshot.
        addr = 9'h010; rd_req = 1'b1;
        push_all(model_rd(9'h010), cyc);
        step();
        rd_req = 1'b0;
        wr_op(9'h010, 9'h1FF);
        idle(6);
        rd_op(9'h010);

        // Reset right after accept: LAT=1 has already responded, the others must abort.
        addr = 9'h005; rd_req = 1'b1;
        sbq[0].push_back('{dat: model_rd(9'h005), cyc: cyc + 1});
        step();
        rd_req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        ledr_m = '0; hex_m = '0; err_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_busy%0d", i), 32'(busy_w[i]), 32'd0);
        end
        chk_regs("abort");
        idle(6);

        // Index wrap within the RAM.
        wr_op(9'h07F, 9'h111);
        wr_op(9'h000, 9'h0AA);
        rd_op(9'h07F);
        rd_op(9'h000);

        idle(8);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sb_drained_lat%0d", LAT[i]), 32'(sbq[i].size()), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
